// File: rtl/axis_digest_collector.sv
// axis_digest_collector
// Collects a multi-word digest from an AXI-Stream hash-core transmitter into
// one wide register and holds it for a consumer until digest_ack.
//
// Handshake: a beat transfers on a rising ACLK edge where TVALID=1 and
// TREADY=1. TREADY depends only on state (and reset), never on TVALID: it is
// high in IDLE/COLLECT and low in HOLD. The consumer side is a level
// digest_valid released by digest_ack while in HOLD.
module axis_digest_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGEST_BITS = 512
) (
  input  logic                                         ACLK,
  input  logic                                         ARESET,
  input  logic                                         TVALID,
  output logic                                         TREADY,
  input  logic [DATA_WIDTH-1:0]                        TDATA,
  input  logic [DATA_WIDTH/8-1:0]                      TKEEP,
  input  logic                                         TLAST,
  input  logic [3:0]                                   TUSER,
  input  logic                                         TID,
  output logic [DIGEST_BITS-1:0]                       digest,
  output logic [$clog2(DIGEST_BITS/DATA_WIDTH):0]      digest_words,
  output logic [3:0]                                   digest_user,
  output logic                                         digest_id,
  output logic                                         digest_valid,
  input  logic                                         digest_ack,
  output logic                                         overflow,
  output logic [1:0]                                   fsm_state
);

  localparam int DEPTH = DIGEST_BITS / DATA_WIDTH;
  localparam int WCW   = $clog2(DEPTH) + 1;
  localparam int KW    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                  state;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   kept;

  // Ready is a pure function of state; low while reset is asserted.
  assign TREADY    = !ARESET && (state != S_HOLD);
  assign accept    = TVALID && TREADY;
  assign fsm_state = state;

  // Zero the bytes whose TKEEP qualifier is low.
  always_comb begin
    kept = '0;
    for (int b = 0; b < KW; b++) begin
      kept[b*8 +: 8] = TKEEP[b] ? TDATA[b*8 +: 8] : 8'h00;
    end
  end

  // Frame FSM: assemble words LSB-first, saturate on overflow, hold until ack.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= S_IDLE;
      digest       <= '0;
      digest_words <= '0;
      digest_user  <= '0;
      digest_id    <= 1'b0;
      digest_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // New frame: wipe any old digest, then place word 0.
            digest                   <= '0;
            digest[DATA_WIDTH-1:0]   <= kept;
            digest_words             <= WCW'(1);
            if (TLAST) begin
              state        <= S_HOLD;
              digest_user  <= TUSER;
              digest_id    <= TID;
              digest_valid <= 1'b1;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (accept) begin
            if (digest_words == WCW'(DEPTH)) begin
              // Register full: drop the word but remember it happened.
              overflow <= 1'b1;
            end else begin
              for (int k = 0; k < DEPTH; k++) begin
                if (digest_words == WCW'(k)) begin
                  digest[k*DATA_WIDTH +: DATA_WIDTH] <= kept;
                end
              end
              digest_words <= digest_words + WCW'(1);
            end
            if (TLAST) begin
              state        <= S_HOLD;
              digest_user  <= TUSER;
              digest_id    <= TID;
              digest_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (digest_ack) begin
            state        <= S_IDLE;
            digest_valid <= 1'b0;
            digest_words <= '0;
            overflow     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
